float_divider: RTL
==================

Name: float_divider

Overview:
- Sequential IEEE754 single-precision divider. Computes res = op1 / op2.
- It is the inverse-operation companion to the team's single-precision multiplier and uses the same ready/op1/op2 -> res/done handshake, so both cores can share one FPU issue slot.
- Mantissa quotient is built by iterative restoring division, one bit per cycle.
- Fixed latency, one operation in flight.

Parameters:
- QNAN, 32'h7FC0_0000, canonical quiet NaN returned for every invalid/NaN result
- QBITS, 26, quotient bits generated (1 integer + 25 fraction: covers normalise shift + guard); sticky comes from the remainder

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low; low clears all state immediately
- ready  in  1  start strobe; op1/op2 captured on the rising edge where ready=1 and the core is IDLE
- op1  in  32  dividend, IEEE754 single
- op2  in  32  divisor, IEEE754 single
- res  out  32  quotient; valid while done=1, then held until the next done
- done  out  1  one-cycle pulse, result valid

Behaviour:
- Reset (rst=0): state=IDLE, res=0, done=0, all internal registers 0. This applies at any time, including mid-operation; the in-flight operation is discarded and no done is produced.
- FSM states:
  - IDLE: on ready=1, latch operands -> UNPACK.
  - UNPACK: 1 cycle. Classify operands (zero/denormal/inf/NaN/normal). Form 24-bit mantissas with the hidden 1. exp_tmp = ea - eb + 127 as 10-bit signed. sign = sa ^ sb. Set special flag/value. -> DIV.
  - DIV: QBITS cycles; counter runs 25 down to 0. Each cycle: rem_trial = rem - divisor; if rem_trial >= 0 then q bit = 1 and rem = rem_trial; rem <<= 1. Remainder is 26 bits wide. -> ROUND.
  - ROUND: 1 cycle. If q[25]=0, shift left 1 and exp_tmp -= 1. Take 24 bits plus guard; sticky = |rem. Round to nearest, ties to even. A mantissa carry-out increments the exponent. -> OUT.
  - OUT: register res, done=1 for exactly one cycle -> IDLE.
- Latency: ready sampled at edge k gives done=1 after edge k+29 (1 UNPACK + 26 DIV + 1 ROUND + 1 OUT). Latency is identical for special cases; they run through DIV with the result ignored.
- Back-to-back issue: the earliest accepted ready is in the cycle done is high, i.e. in IDLE after OUT.
- ready=1 while busy (not IDLE): ignored. Operands are not re-latched.
- Denormal inputs are flushed to signed zero. Results with final exponent <= 0 flush to signed zero (sign kept). Final exponent >= 255 gives signed inf 0x7F800000 | sign<<31.
- Special-case priority:
  1. Either operand NaN -> QNAN.
  2. inf/inf or 0/0 -> QNAN.
  3. inf/x or x/0 (x nonzero) -> signed inf.
  4. 0/x or x/inf -> signed zero.
  5. Otherwise normal path.
- NaN output sign is always 0 (QNAN exactly).

Decomposition:
- Shared package fp32_pkg:
  - constants EXP_W=8, MAN_W=23, BIAS=127, EXP_MAX=255, POS_INF, QNAN
  - enum type for fp class {ZERO, NORM, INF, NAN}
  - classify function, reused by the multiplier
  - FSM state typedef local to this block.
- One natural sub-module: fp32_mant_div, the iterative restoring mantissa divider.
  - Interface: start, 24-bit dividend/divisor, 26-bit quotient, sticky, busy.
  - The top level owns unpack, special handling, rounding and the handshake.

Test Plan:
- 5.0/2.0 (0x40A00000 / 0x40000000) with ready high one cycle -> done exactly 29 cycles later, res=0x40200000 (2.5).
- 1.0/3.0 (0x3F800000 / 0x40400000) -> res=0x3EAAAAAB, exercising the round-up path with sticky=1.
- Special cases:
  - 1.0 / -0.0 (0x3F800000 / 0x80000000) -> 0xFF800000.
  - 0/0 -> 0x7FC00000.
  - -inf / 2437.716 (0xFF800000 / 0x45185B75) -> 0xFF800000.
- Range limits:
  - 0x7F7FFFFF / 0x3F000000 (max / 0.5) -> 0x7F800000 (overflow).
  - 0x00800000 / 0x40000000 (min normal / 2) -> 0x00000000 (flush-to-zero).
- ready re-asserted with new operands at cycles k+1 and k+10 of an operation -> single done at k+29 with the first result. rst pulsed low at k+15 -> done stays 0, res=0; a new ready afterwards completes normally.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared IEEE754 single-precision constants, operand classes and classifier.
// Used by both the divider and the multiplier cores.
package fp32_pkg;

   localparam int unsigned EXP_W   = 8;
   localparam int unsigned MAN_W   = 23;
   localparam int unsigned BIAS    = 127;
   localparam int unsigned EXP_MAX = 255;
   localparam int unsigned QBITS   = 26;

   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

   // Denormals report as ZERO so callers flush them without extra logic.
   function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      fp_class_t c;
      if (e == '0) begin
         c = ZERO;
      end else if (e == EXP_W'(EXP_MAX)) begin
         c = (m == '0) ? INF : NAN;
      end else begin
         c = NORM;
      end
      return c;
   endfunction

endpackage

// File: rtl/fp32_mant_div.sv
// Iterative restoring divider for 24-bit mantissas, one quotient bit per cycle.
// Produces QBITS quotient bits (1 integer + fraction) and a sticky flag from the remainder.
module fp32_mant_div
   import fp32_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [23:0]       dividend,
   input  logic [23:0]       divisor,
   output logic [QBITS-1:0]  quotient,
   output logic              sticky,
   output logic              busy
);

   logic [25:0]      rem_q;
   logic [23:0]      dvs_q;
   logic [QBITS-1:0] quo_q;
   logic [4:0]       cnt_q;
   logic             busy_q;
   logic [26:0]      trial;
   logic [25:0]      rem_keep;

   // The extra top bit of the trial difference is its sign: set means restore.
   always_comb begin
      trial    = {1'b0, rem_q} - {3'b000, dvs_q};
      rem_keep = trial[26] ? rem_q : trial[25:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q  <= '0;
         dvs_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         rem_q  <= {2'b00, dividend};
         dvs_q  <= divisor;
         quo_q  <= '0;
         cnt_q  <= 5'(QBITS - 1);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         quo_q[cnt_q] <= ~trial[26];
         rem_q        <= rem_keep << 1;
         cnt_q        <= cnt_q - 5'd1;
         if (cnt_q == 5'd0) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign quotient = quo_q;
   assign sticky   = |rem_q;
   assign busy     = busy_q;

endmodule

// File: rtl/float_divider.sv
// Sequential IEEE754 single-precision divider, res = op1 / op2, fixed latency.
// Shares the ready/op1/op2 -> res/done handshake with the single-precision multiplier.
module float_divider
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ready,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic [31:0] res,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, OUT} state_t;

   state_t      state_q;
   logic [31:0] opa_q;
   logic [31:0] opb_q;
   logic        sign_q;
   logic [9:0]  exp_q;
   logic        special_q;
   logic [31:0] spec_val_q;
   logic [4:0]  cnt_q;
   logic [31:0] result_q;

   fp_class_t   cls_a;
   fp_class_t   cls_b;
   logic        sign_nxt;
   logic [9:0]  exp_nxt;
   logic        special_nxt;
   logic [31:0] spec_val_nxt;

   logic              div_start;
   logic [QBITS-1:0]  quo;
   logic              div_sticky;
   logic              div_busy;

   logic [23:0] mant;
   logic        guard;
   logic        stk;
   logic [24:0] mant_r;
   logic [9:0]  e_adj;
   logic [9:0]  e_fin;
   logic [22:0] frac;
   logic [31:0] rnd_res;

   // Operand classification and special-result selection, consumed in UNPACK.
   always_comb begin
      cls_a        = classify(opa_q[30:23], opa_q[MAN_W-1:0]);
      cls_b        = classify(opb_q[30:23], opb_q[MAN_W-1:0]);
      sign_nxt     = opa_q[31] ^ opb_q[31];
      exp_nxt      = {2'b00, opa_q[30:23]} - {2'b00, opb_q[30:23]} + 10'(BIAS);
      special_nxt  = 1'b1;
      spec_val_nxt = QNAN;
      if (cls_a == NAN || cls_b == NAN) begin
         spec_val_nxt = QNAN;
      end else if ((cls_a == INF && cls_b == INF) || (cls_a == ZERO && cls_b == ZERO)) begin
         spec_val_nxt = QNAN;
      end else if (cls_a == INF || cls_b == ZERO) begin
         spec_val_nxt = POS_INF | {sign_nxt, 31'b0};
      end else if (cls_a == ZERO || cls_b == INF) begin
         spec_val_nxt = {sign_nxt, 31'b0};
      end else begin
         special_nxt  = 1'b0;
         spec_val_nxt = '0;
      end
   end

   assign div_start = (state_q == UNPACK);

   fp32_mant_div u_mant_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend ({1'b1, opa_q[MAN_W-1:0]}),
      .divisor  ({1'b1, opb_q[MAN_W-1:0]}),
      .quotient (quo),
      .sticky   (div_sticky),
      .busy     (div_busy)
   );

   // Normalise, round to nearest even, then range-check the final exponent.
   always_comb begin
      if (quo[QBITS-1]) begin
         mant  = quo[25:2];
         guard = quo[1];
         stk   = quo[0] | div_sticky;
         e_adj = exp_q;
      end else begin
         mant  = quo[24:1];
         guard = quo[0];
         stk   = div_sticky;
         e_adj = exp_q - 10'd1;
      end
      mant_r = {1'b0, mant} + {24'b0, guard & (stk | mant[0])};
      if (mant_r[24]) begin
         e_fin = e_adj + 10'd1;
         frac  = mant_r[23:1];
      end else begin
         e_fin = e_adj;
         frac  = mant_r[22:0];
      end
      if ($signed(e_fin) <= $signed(10'sd0)) begin
         rnd_res = {sign_q, 31'b0};
      end else if ($signed(e_fin) >= $signed(10'(EXP_MAX))) begin
         rnd_res = POS_INF | {sign_q, 31'b0};
      end else begin
         rnd_res = {sign_q, e_fin[7:0], frac};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         opa_q      <= '0;
         opb_q      <= '0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         special_q  <= 1'b0;
         spec_val_q <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         res        <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ready) begin
                  opa_q   <= op1;
                  opb_q   <= op2;
                  state_q <= UNPACK;
               end
            end
            UNPACK: begin
               sign_q     <= sign_nxt;
               exp_q      <= exp_nxt;
               special_q  <= special_nxt;
               spec_val_q <= spec_val_nxt;
               cnt_q      <= 5'(QBITS - 1);
               state_q    <= DIV;
            end
            DIV: begin
               if (cnt_q == 5'd0) begin
                  state_q <= ROUND;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            ROUND: begin
               // Divider has retired its last bit by now; the check is an interlock only.
               if (!div_busy) begin
                  result_q <= special_q ? spec_val_q : rnd_res;
                  state_q  <= OUT;
               end
            end
            OUT: begin
               res     <= result_q;
               done    <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
